// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side sequencer for the UART RX path.
// Oversamples RX_IN at P ticks per bit and walks IDLE/START/DATA/PARITY/STOP.
// Takes a majority-of-3 vote around mid-bit, drives the deserializer strobes and
// checks the start bit, parity and stop bit.
//
// Ports:
//   CLK          oversampling clock, one Prescale tick per edge
//   RST          synchronous active-high reset
//   RX_IN        serial line (synchronised, idle high)
//   Prescale     oversampling ratio: 8, 16 or 32; anything else acts as 8
//   PAR_EN       frame carries a parity bit
//   PAR_TYP      0 = even, 1 = odd parity
//   edge_cnt     tick index within the current bit
//   bit_cnt      0 start, 1..8 data, 9 parity, 9/10 stop
//   sampled_bit  registered majority vote of the current bit
//   deser_en     one-cycle pulse on the last tick of each data bit
//   data_valid   one-cycle pulse after an error-free frame
//   par_err      parity mismatch, sticky until next start detection
//   stp_err      stop bit sampled 0, sticky until next start detection
//   strt_glitch  one-cycle pulse when a start bit is rejected
//   busy         high outside IDLE
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  sampled_bit,
  output logic                  deser_en,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch,
  output logic                  busy
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

  state_t                r_state, w_next;
  logic [PRESCALE_W-1:0] r_p, r_edge;
  logic [PRESCALE_W-1:0] w_p_dec, w_last, w_half;
  logic [3:0]            r_bit;
  logic                  r_s0, r_s1, r_smp;
  logic                  r_acc, r_par_err, r_stp_err, r_dv, r_glitch;
  logic                  w_start, w_bit_end, w_maj;

  // Unsupported ratios collapse to 8.
  always_comb begin
    w_p_dec = PRESCALE_W'(8);
    if (Prescale == PRESCALE_W'(16) || Prescale == PRESCALE_W'(32))
      w_p_dec = Prescale;
  end

  assign w_last    = r_p - PRESCALE_W'(1);
  assign w_half    = r_p >> 1;
  assign w_start   = (r_state == S_IDLE) && !RX_IN;
  assign w_bit_end = (r_state != S_IDLE) && (r_edge == w_last);
  // Third vote is taken live on the P/2+1 tick so the result lands one tick later.
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!RX_IN) w_next = S_START;
      S_START:  if (w_bit_end) w_next = r_smp ? S_IDLE : S_DATA;
      S_DATA:   if (w_bit_end && r_bit == LAST_DATA) w_next = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end) w_next = S_STOP;
      S_STOP:   if (w_bit_end) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    deser_en = (r_state == S_DATA) && w_bit_end;
    busy     = (r_state != S_IDLE);
  end

  // Edge / bit counters and latched ratio. The detection cycle is edge 0,
  // so the counter enters START already at 1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_p    <= '0;
      r_edge <= '0;
      r_bit  <= '0;
    end else if (r_state == S_IDLE) begin
      r_bit <= '0;
      if (!RX_IN) begin
        r_p    <= w_p_dec;
        r_edge <= PRESCALE_W'(1);
      end else begin
        r_edge <= '0;
      end
    end else if (w_bit_end) begin
      r_edge <= '0;
      case (r_state)
        S_START:  r_bit <= r_smp ? 4'd0 : 4'd1;
        S_DATA:   r_bit <= r_bit + 4'd1;  // last data bit -> 9, parity or stop
        S_PARITY: r_bit <= 4'd10;
        default:  r_bit <= 4'd0;
      endcase
    end else begin
      r_edge <= r_edge + PRESCALE_W'(1);
    end
  end

  // Mid-bit majority sampling.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s0  <= 1'b0;
      r_s1  <= 1'b0;
      r_smp <= 1'b1;
    end else if (r_state != S_IDLE) begin
      if (r_edge == w_half - PRESCALE_W'(1)) r_s0  <= RX_IN;
      if (r_edge == w_half)                  r_s1  <= RX_IN;
      if (r_edge == w_half + PRESCALE_W'(1)) r_smp <= w_maj;
    end
  end

  // Parity accumulator, error flags and strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc     <= 1'b0;
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
      r_dv      <= 1'b0;
      r_glitch  <= 1'b0;
    end else begin
      r_dv     <= 1'b0;
      r_glitch <= 1'b0;
      if (w_start) begin
        r_par_err <= 1'b0;
        r_stp_err <= 1'b0;
      end
      if (w_bit_end) begin
        case (r_state)
          S_START:  if (r_smp) r_glitch <= 1'b1;
                    else       r_acc    <= PAR_TYP;  // odd parity seeds with 1
          S_DATA:   r_acc <= r_acc ^ r_smp;
          S_PARITY: r_par_err <= r_acc ^ r_smp;
          S_STOP: begin
            r_stp_err <= ~r_smp;
            r_dv      <= r_smp & ~r_par_err;
          end
          default: ;
        endcase
      end
    end
  end

  assign edge_cnt    = r_edge;
  assign bit_cnt     = r_bit;
  assign sampled_bit = r_smp;
  assign data_valid  = r_dv;
  assign par_err     = r_par_err;
  assign stp_err     = r_stp_err;
  assign strt_glitch = r_glitch;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART RX path. It oversamples RX_IN at Prescale × baud and runs the frame FSM (IDLE/START/DATA/PARITY/STOP). It owns the edge and bit counters, takes a majority-of-3 sample at mid-bit, and drives the deserializer's enable, counter and sampled-bit inputs. It also checks start glitch, parity and stop bit, and emits a one-cycle data_valid strobe per good frame.

Parameters:
DATA_WIDTH, 8, data bits per frame. Fixed at 8; bit_cnt encoding depends on it.
PRESCALE_W, 6, width of Prescale and edge_cnt. Must hold 32.

Ports:
CLK  in  1  oversampling clock. Every edge is one Prescale tick.
RST  in  1  synchronous, active-high reset.
RX_IN  in  1  serial line, already synchronised to CLK. Idle level is 1.
Prescale  in  6  oversampling ratio. Legal values are 8, 16 and 32; any other value is treated as 8.
PAR_EN  in  1  1 = frame carries a parity bit.
PAR_TYP  in  1  0 = even parity, 1 = odd parity.
edge_cnt  out  6  tick index within the current bit, 0..P-1.
bit_cnt  out  4  0 = start bit, 1..8 = data bits, 9 = parity bit, 9 or 10 = stop bit.
sampled_bit  out  1  registered majority-of-3 value for the current bit.
deser_en  out  1  one-cycle pulse at edge_cnt==P-1 of each data bit (bit_cnt 1..8).
data_valid  out  1  one-cycle pulse when a frame completes with no errors.
par_err  out  1  parity mismatch. Sticky until the next start bit is detected.
stp_err  out  1  stop bit sampled 0. Sticky until the next start bit is detected.
strt_glitch  out  1  one-cycle pulse when the start bit is rejected.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - state goes to IDLE.
  - All outputs are 0, except sampled_bit, which is 1.
  - Internal parity accumulator and latched prescale (P) are cleared.
  - Reset mid-frame aborts the frame with no strobes.
- P is latched from Prescale on start detection. Prescale changes mid-frame are ignored.
- IDLE:
  - edge_cnt=0, bit_cnt=0.
  - RX_IN==0 seen at cycle T0: that cycle counts as edge 0. At T0+1 the state is START with edge_cnt=1.
  - par_err and stp_err clear at T0+1.
- Edge counter:
  - Increments every cycle outside IDLE.
  - At P-1 it wraps to 0 and bit_cnt increments (subject to the state transitions below).
- Sampling:
  - RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1.
  - The majority of the three is registered into sampled_bit, visible from edge_cnt = P/2+2.
  - sampled_bit holds until the next bit's update.
- START, at edge_cnt==P-1:
  - sampled_bit==1: go to IDLE and pulse strt_glitch on the next cycle.
  - Otherwise: go to DATA with bit_cnt=1, edge_cnt=0, and parity accumulator = PAR_TYP.
- DATA, at edge_cnt==P-1:
  - Pulse deser_en the same cycle.
  - XOR sampled_bit into the parity accumulator.
  - If bit_cnt==8, go to PARITY (PAR_EN=1) or STOP (PAR_EN=0). Otherwise bit_cnt++.
- PARITY, at edge_cnt==P-1:
  - par_err <= accumulator XOR sampled_bit, i.e. par_err=1 when the received parity mismatches the expected value.
  - Go to STOP with bit_cnt=10.
- STOP (bit_cnt=9 without parity, 10 with parity), at edge_cnt==P-1:
  - stp_err <= ~sampled_bit.
  - Go to IDLE.
  - data_valid pulses on the next cycle only if the new stp_err is 0 and par_err is 0.
- Frame timing (start at T0, last stop edge at T0+N·P-1, N=10 without parity or 11 with parity):
  - data_valid is high in cycle T0+N·P only.
  - The next start bit can be detected from T0+N·P at the earliest (one-tick resync loss per frame; accepted).
- RX_IN is not checked for mid-bit stability beyond the majority vote. Line noise is resolved by the vote only.
- PAR_EN and PAR_TYP are sampled live but must be held stable for a frame; changing them mid-frame is undefined.

Test Plan:
1. RST held high for 3 cycles, RX_IN=1, then released → all outputs 0, sampled_bit=1, busy=0, no strobes for 100 cycles.
2. P=8, PAR_EN=0, frame 0xA5 sent LSB-first (start 0, data bits 1,0,1,0,0,1,0,1, stop 1) with start detected at T0 → 8 deser_en pulses at T0+15, +23, …, +71 with bit_cnt 1..8; data_valid at T0+80; par_err=stp_err=0.
3. P=16, PAR_EN=1, PAR_TYP=0, 0xA5 with parity bit 0 → data_valid at T0+176. Same frame with parity bit 1 → par_err=1 from T0+160 (sticky), no data_valid.
4. P=32, PAR_EN=0, stop bit driven 0 → stp_err=1 at T0+320, no data_valid. stp_err clears when the next frame's start is detected, and that frame is received cleanly.
5. P=16, RX_IN low for only 2 cycles, then high → strt_glitch pulse at T0+16, busy=0 afterwards, no deser_en.
6. Prescale=12 → behaves exactly as P=8. Prescale changed from 8 to 32 mid-frame → frame still completes at T0+80. Back-to-back frames 0x00 then 0xFF → two data_valid pulses, 80 cycles apart plus the restart slip.
